// File: rtl/fib_bcd_gen.sv
// Fibonacci term generator producing packed BCD words through a valid/ready port.
// Optional `last` output marking the final requested term is enabled by defining FIB_LAST_EN.
module fib_bcd_gen #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            n_terms,
  output logic [4*DIGITS-1:0]   term_bcd,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
`ifdef FIB_LAST_EN
  ,
  output logic                  last
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [4:0]      n_cap;
  logic [4:0]      cnt;
  logic [4:0]      cnt_next;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W-1:0]    acc;
  logic [W-1:0]    sum_full;
  logic [DW-1:0]   didx;
  logic            carry;
  logic            gap;
  logic            hs;
  logic            last_digit;
  logic [4:0]      dsum;
  logic [3:0]      dres;
  logic            dcarry;

  // Handshake: a term transfers on any rising edge where valid && ready;
  // valid stays high and term_bcd stays stable until that edge.
  assign valid      = (state == S_OUT) && !gap;
  assign hs         = valid && ready;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign cnt_next   = cnt + 5'd1;
  assign last_digit = (int'(didx) == DIGITS - 1);

`ifdef FIB_LAST_EN
  assign last = valid && (cnt_next == n_cap);
`endif

  // One BCD digit of a + b per cycle; values 10..19 wrap by adding 6.
  always_comb begin
    dsum     = {1'b0, a[4*int'(didx) +: 4]} + {1'b0, b[4*int'(didx) +: 4]} + {4'b0, carry};
    dcarry   = (dsum > 5'd9);
    dres     = dcarry ? (dsum[3:0] + 4'd6) : dsum[3:0];
    sum_full = acc;
    sum_full[4*int'(didx) +: 4] = dres;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (n_terms == 5'd0) ? S_DONE : S_OUT;
      end
      S_OUT: begin
        if (hs) begin
          if (cnt_next == n_cap)      state_next = S_DONE;
          else if (cnt_next == 5'd1)  state_next = S_OUT;
          else                        state_next = S_ADD;
        end
      end
      S_ADD: begin
        if (last_digit) state_next = dcarry ? S_DONE : S_OUT;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_cap    <= '0;
      cnt      <= '0;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      term_bcd <= '0;
      didx     <= '0;
      carry    <= 1'b0;
      gap      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_cap    <= n_terms;
            overflow <= 1'b0;
            cnt      <= '0;
            a        <= '0;
            b        <= '0;
            term_bcd <= '0;
            gap      <= 1'b0;
          end
        end
        S_OUT: begin
          gap <= 1'b0;
          if (hs) begin
            cnt <= cnt_next;
            if (cnt_next != n_cap) begin
              if (cnt_next == 5'd1) begin
                // F1 is loaded directly; valid drops for one cycle while it settles.
                term_bcd <= {{(W-1){1'b0}}, 1'b1};
                b        <= {{(W-1){1'b0}}, 1'b1};
                gap      <= 1'b1;
              end else begin
                didx  <= '0;
                carry <= 1'b0;
              end
            end
          end
        end
        S_ADD: begin
          acc[4*int'(didx) +: 4] <= dres;
          carry <= dcarry;
          didx  <= didx + 1'b1;
          if (last_digit) begin
            if (dcarry) begin
              overflow <= 1'b1;
            end else begin
              a        <= b;
              b        <= sum_full;
              term_bcd <= sum_full;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_bcd_gen.sv
// Bench for fib_bcd_gen: integer Fibonacci reference converted to BCD, compared
// against every accepted term under several ready patterns, plus reset/start corner cases.
module tb_fib_bcd_gen;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    n_terms;
  logic [W-1:0]  term_bcd;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef FIB_LAST_EN
  logic          last;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  fib_bcd_gen #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n_terms  (n_terms),
    .term_bcd (term_bcd),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
`ifdef FIB_LAST_EN
    ,
    .last     (last)
`endif
  );

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r;
    longint x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Expected terms: F(0)..F(n-1) as long as they fit in DIGITS decimal digits.
  task automatic build_model(input int n, output bit ovf);
    longint f0, f1, t, lim;
    exp_q.delete();
    ovf = 1'b0;
    f0 = 0;
    f1 = 1;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    for (int i = 0; i < n; i++) begin
      if (f0 >= lim) begin
        ovf = 1'b1;
        break;
      end
      exp_q.push_back(to_bcd(f0));
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  // rmode: 0 = ready always high, 1 = toggles every 3 cycles, 2 = random.
  // poke: fire random start pulses while the sequence is running.
  task automatic run_seq(input int n, input int rmode, input bit poke, input string tag);
    bit           exp_ovf;
    int           exp_n, acc, done_cnt, done_cyc, low_run;
    bit           finished, prev_hold;
    logic [W-1:0] prev_term, want;
    build_model(n, exp_ovf);
    exp_n = exp_q.size();
    acc = 0; done_cnt = 0; done_cyc = -1; low_run = 0;
    finished = 1'b0; prev_hold = 1'b0; prev_term = '0;

    @(negedge clk);
    start = 1'b1;
    n_terms = 5'(n);
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL %s ovf_clear: got %b want 0", tag, overflow);
    else pass_cnt++;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ((cyc / 3) % 2) == 0;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 0) begin
        chk_cnt++;
        if (valid !== (n > 0)) $display("FAIL %s valid_rise: got %b want %b", tag, valid, (n > 0));
        else pass_cnt++;
      end
      if (prev_hold) begin
        chk_cnt++;
        if (valid !== 1'b1 || term_bcd !== prev_term)
          $display("FAIL %s hold: got valid=%b term=%h want valid=1 term=%h", tag, valid, term_bcd, prev_term);
        else pass_cnt++;
      end
      prev_hold = valid && !ready;
      prev_term = term_bcd;
`ifdef FIB_LAST_EN
      if (valid) begin
        chk_cnt++;
        if (last !== (acc + 1 == n)) $display("FAIL %s last: got %b want %b", tag, last, (acc + 1 == n));
        else pass_cnt++;
      end
`endif
      if (valid && ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra_term: got %h want none", tag, term_bcd);
        end else begin
          want = exp_q.pop_front();
          if (term_bcd !== want) $display("FAIL %s term%0d: got %h want %h", tag, acc, term_bcd, want);
          else pass_cnt++;
          if (rmode == 0 && acc >= 1) begin
            chk_cnt++;
            if (low_run != ((acc == 1) ? 1 : DIGITS))
              $display("FAIL %s gap%0d: got %0d want %0d", tag, acc, low_run, (acc == 1) ? 1 : DIGITS);
            else pass_cnt++;
          end
        end
        acc++;
        low_run = 0;
      end else if (!valid) begin
        low_run++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1'b1;
        chk_cnt++;
        if (overflow !== exp_ovf || valid !== 1'b0 || busy !== 1'b1)
          $display("FAIL %s done_flags: got ovf=%b valid=%b busy=%b want ovf=%b valid=0 busy=1",
                   tag, overflow, valid, busy, exp_ovf);
        else pass_cnt++;
      end
      if (poke && busy && !done && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        n_terms = 5'($urandom_range(0, 31));
      end
    end

    chk_cnt++;
    if (!finished) $display("FAIL %s timeout: got no done want done", tag);
    else pass_cnt++;
    chk_cnt++;
    if (acc != exp_n || exp_q.size() != 0) $display("FAIL %s term_count: got %0d want %0d", tag, acc, exp_n);
    else pass_cnt++;
    if (n == 0) begin
      chk_cnt++;
      if (done_cyc != 0) $display("FAIL %s zero_done_cycle: got %0d want 0", tag, done_cyc);
      else pass_cnt++;
    end

    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || overflow !== exp_ovf)
      $display("FAIL %s after_done: got done=%b busy=%b valid=%b ovf=%b want 0 0 0 %b",
               tag, done, busy, valid, overflow, exp_ovf);
    else pass_cnt++;
  endtask

  task automatic check_idle(input string tag);
    chk_cnt++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || term_bcd !== '0)
      $display("FAIL %s: got valid=%b busy=%b done=%b ovf=%b term=%h want all 0",
               tag, valid, busy, done, overflow, term_bcd);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    n_terms = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_basic();
    run_seq(8, 0, 1'b0, "basic8");
  endtask

  task automatic test_backpressure();
    run_seq(8, 1, 1'b0, "toggle8");
  endtask

  task automatic test_zero();
    run_seq(0, 0, 1'b0, "zero");
  endtask

  task automatic test_overflow();
    run_seq(25, 0, 1'b0, "ovf25");
    run_seq(21, 2, 1'b0, "exact21");
    run_seq(22, 0, 1'b0, "ovf22");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_clears_ovf");
  endtask

  task automatic test_start_ignored();
    run_seq(12, 0, 1'b1, "poke12");
    run_seq(7, 1, 1'b1, "poke7");
  endtask

  task automatic test_reset_mid();
    int acc;
    acc = 0;
    @(negedge clk);
    ready = 1'b1;
    start = 1'b1;
    n_terms = 5'd10;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && acc < 3; cyc++) begin
      if (valid) acc++;
      @(negedge clk);
    end
    chk_cnt++;
    if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL mid_in_add: got busy=%b valid=%b want 1 0", busy, valid);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_reset_state");
    reset = 1'b0;
    run_seq(3, 0, 1'b0, "after_reset3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_seq($urandom_range(1, 31), 2, 1'b1, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
